instr_word_encoder: RTL and testbench

Sequential RV32I instruction encoder and program loader: the inverse of the control-path decoder. It accepts decoded instruction fields (format, opcode, funct3, funct7, register addresses, immediate) over a valid/ready handshake, packs each into a 32-bit instruction word, and streams the words into instruction memory at consecutive word addresses. It sits between the test/boot controller and the instruction memory write port, and is used to load programs without an external hex file.

---
 rtl/instr_word_encoder.sv | 183 ++++++++++++++++++
 tb/tb_instr_word_encoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_word_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_word_encoder
//  Purpose  : RV32I instruction encoder and program loader. Accepts decoded
//             instruction fields over a valid/ready handshake, packs them
//             into 32-bit instruction words and writes them to instruction
//             memory at consecutive word addresses.
//  Ports    : iClk/iRstN        clock, asynchronous active-low reset
//             iStart/iBaseAddr/iCount   load command (honoured in IDLE only)
//             iValid/oReady     field-set handshake
//             iFormat..iImm     decoded instruction fields
//             oMemWe/oMemAddr/oMemWData   instruction memory write port
//             oBusy/oDone/oError          status
//  Options  : INSTR_ENCODE_CHECK_EN - adds immediate range/alignment checks
//             that raise oError (the word is still written, truncated).
//  Revision : 1.0 - initial release
// ============================================================================
module instr_word_encoder #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iBaseAddr,
    input  logic [15:0]           iCount,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [2:0]            iFormat,
    input  logic [6:0]            iOpCode,
    input  logic [2:0]            iFunct3,
    input  logic [6:0]            iFunct7,
    input  logic [4:0]            iRs1,
    input  logic [4:0]            iRs2,
    input  logic [4:0]            iRd,
    input  logic [31:0]           iImm,
    output logic                  oMemWe,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [31:0]           oMemWData,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oError
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_RUN    = 2'd1;
    localparam logic [1:0]  S_DONE   = 2'd2;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [15:0]           remaining;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_we;
    logic                  error;
    logic                  start_ok;
    logic                  accept;
    logic [31:0]           word;
    logic                  fmt_illegal;
    logic                  imm_bad;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (iStart) begin
                    state_next = (iCount != 16'd0) ? S_RUN : S_DONE;
                end
            end
            // Leave RUN once the final word has been presented to memory.
            S_RUN: begin
                if ((remaining == 16'd0) && mem_we) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        oReady = (state == S_RUN) && (remaining != 16'd0);
        oBusy  = (state != S_IDLE);
        oDone  = (state == S_DONE);
    end

    assign start_ok = (state == S_IDLE) && iStart;
    assign accept   = iValid && oReady;

    // ------------------------------------------------------------------
    // Field packing
    // ------------------------------------------------------------------
    always_comb begin
        word        = NOP_WORD;
        fmt_illegal = 1'b0;
        case (iFormat)
            3'd0: word = {iFunct7, iRs2, iRs1, iFunct3, iRd, iOpCode};
            3'd1: word = {iImm[11:0], iRs1, iFunct3, iRd, iOpCode};
            3'd2: word = {iImm[11:5], iRs2, iRs1, iFunct3, iImm[4:0], iOpCode};
            3'd3: word = {iImm[12], iImm[10:5], iRs2, iRs1, iFunct3,
                          iImm[4:1], iImm[11], iOpCode};
            3'd4: word = {iImm[31:12], iRd, iOpCode};
            3'd5: word = {iImm[20], iImm[10:1], iImm[11], iImm[19:12],
                          iRd, iOpCode};
            default: begin
                word        = NOP_WORD;
                fmt_illegal = 1'b1;
            end
        endcase
    end

`ifdef INSTR_ENCODE_CHECK_EN
    // An immediate fits N signed bits when every bit from N-1 upward
    // equals the sign bit.
    always_comb begin
        imm_bad = 1'b0;
        case (iFormat)
            3'd1, 3'd2: imm_bad = !((&iImm[31:11]) || !(|iImm[31:11]));
            3'd3:       imm_bad = !((&iImm[31:12]) || !(|iImm[31:12])) || iImm[0];
            3'd4:       imm_bad = |iImm[11:0];
            3'd5:       imm_bad = !((&iImm[31:20]) || !(|iImm[31:20])) || iImm[0];
            default:    imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Counters and write stage. The memory never stalls, so the stage
    // register is valid for exactly one cycle per accepted field set.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            remaining <= 16'd0;
            addr      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            error     <= 1'b0;
        end else begin
            mem_we <= accept;
            if (start_ok) begin
                remaining <= iCount;
                addr      <= {iBaseAddr[ADDR_WIDTH-1:2], 2'b00};
                error     <= 1'b0;
            end else if (accept) begin
                remaining <= remaining - 16'd1;
                addr      <= addr + ADDR_WIDTH'(4);
                mem_addr  <= addr;
                mem_wdata <= word;
                if (fmt_illegal || imm_bad) begin
                    error <= 1'b1;
                end
            end
        end
    end

    assign oMemWe    = mem_we;
    assign oMemAddr  = mem_addr;
    assign oMemWData = mem_wdata;
    assign oError    = error;

endmodule
`default_nettype wire

// File: tb/tb_instr_word_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_word_encoder
//  Purpose  : Self-checking bench for instr_word_encoder. Expected writes are
//             queued at each handshake and compared when oMemWe appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_word_encoder;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        iStart;
    logic [31:0] iBaseAddr;
    logic [15:0] iCount;
    logic        iValid;
    logic        oReady;
    logic [2:0]  iFormat;
    logic [6:0]  iOpCode;
    logic [2:0]  iFunct3;
    logic [6:0]  iFunct7;
    logic [4:0]  iRs1, iRs2, iRd;
    logic [31:0] iImm;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic        oBusy, oDone, oError;

    int          checks = 0;
    int          errors = 0;
    int          wr_seen = 0;
    logic [63:0] sb[$];
    logic [31:0] m_addr;
    logic [31:0] exp_word;
    logic        hs;

`ifdef INSTR_ENCODE_CHECK_EN
    localparam logic CHK_ERR = 1'b1;
`else
    localparam logic CHK_ERR = 1'b0;
`endif

    instr_word_encoder #(.ADDR_WIDTH(32)) dut (
        .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iBaseAddr(iBaseAddr),
        .iCount(iCount), .iValid(iValid), .oReady(oReady), .iFormat(iFormat),
        .iOpCode(iOpCode), .iFunct3(iFunct3), .iFunct7(iFunct7), .iRs1(iRs1),
        .iRs2(iRs2), .iRd(iRd), .iImm(iImm), .oMemWe(oMemWe),
        .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oBusy(oBusy),
        .oDone(oDone), .oError(oError)
    );

    always #5 iClk = ~iClk;

    // One clock cycle: score any write at mid-cycle, queue the expected
    // write for a handshake, then step to just after the next rising edge.
    task automatic tick();
        logic [63:0] e;
        @(negedge iClk);
        if (oMemWe) begin
            wr_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", oMemAddr, oMemWData);
            end else begin
                e = sb.pop_front();
                if ({oMemAddr, oMemWData} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             oMemAddr, oMemWData, e[63:32], e[31:0]);
                end
            end
        end
        hs = iValid && oReady;
        if (hs) begin
            sb.push_back({m_addr, exp_word});
            m_addr = m_addr + 32'd4;
        end
        @(posedge iClk);
        #1;
    endtask

    task automatic start(input logic [31:0] base, input logic [15:0] cnt);
        iBaseAddr = base;
        iCount    = cnt;
        iStart    = 1'b1;
        m_addr    = {base[31:2], 2'b00};
        tick();
        iStart    = 1'b0;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] imm,
                        input logic [31:0] word);
        logic got;
        iFormat = fmt; iOpCode = op; iFunct3 = f3; iFunct7 = f7;
        iRs1 = rs1; iRs2 = rs2; iRd = rd; iImm = imm;
        exp_word = word;
        iValid   = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = hs;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL handshake_timeout got=0 expected=1");
        end
    endtask

    task automatic test_reset();
        checks++; if (oMemWe !== 1'b0)       begin errors++; $display("FAIL rst_we got=%b expected=0", oMemWe); end
        checks++; if (oMemAddr !== 32'd0)    begin errors++; $display("FAIL rst_addr got=%h expected=0", oMemAddr); end
        checks++; if (oMemWData !== 32'd0)   begin errors++; $display("FAIL rst_wdata got=%h expected=0", oMemWData); end
        checks++; if ({oBusy, oDone, oError, oReady} !== 4'b0)
            begin errors++; $display("FAIL rst_status got=%b expected=0000", {oBusy, oDone, oError, oReady}); end
    endtask

    task automatic test_program();
        start(32'h100, 16'd4);
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL prog_busy got=%b expected=1", oBusy); end
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h00500093);
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3);
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 32'h0020A423);
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 32'h00208463);
        iValid = 1'b0;
        // cycle N+1: the last write is on the port
        checks++; if (oMemWe !== 1'b1) begin errors++; $display("FAIL prog_lastwe got=%b expected=1", oMemWe); end
        checks++; if (oDone !== 1'b0)  begin errors++; $display("FAIL prog_done_early got=%b expected=0", oDone); end
        tick();
        checks++; if (oDone !== 1'b1)  begin errors++; $display("FAIL prog_done got=%b expected=1", oDone); end
        tick();
        checks++; if ({oDone, oBusy} !== 2'b00) begin errors++; $display("FAIL prog_idle got=%b expected=00", {oDone, oBusy}); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL prog_pending got=%0d expected=0", sb.size()); end
    endtask

    task automatic test_u_j();
        start(32'h0, 16'd2);
        send(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000, 32'h123452B7);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd16, 32'h010000EF);
        iValid = 1'b0;
        tick(); tick(); tick();
        checks++; if (oError !== 1'b0) begin errors++; $display("FAIL uj_error got=%b expected=0", oError); end
    endtask

    task automatic test_count_zero();
        int w0;
        w0 = wr_seen;
        start(32'h500, 16'd0);
        checks++; if ({oDone, oBusy, oReady} !== 3'b110) begin errors++; $display("FAIL zero_done got=%b expected=110", {oDone, oBusy, oReady}); end
        tick();
        checks++; if ({oDone, oBusy, oReady} !== 3'b000) begin errors++; $display("FAIL zero_idle got=%b expected=000", {oDone, oBusy, oReady}); end
        checks++; if (wr_seen != w0) begin errors++; $display("FAIL zero_writes got=%0d expected=%0d", wr_seen, w0); end
    endtask

    task automatic test_wrap();
        start(32'hFFFF_FFFF, 16'd2);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1, 32'h00100093);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'd2, 32'h00200113);
        iValid = 1'b0;
        tick(); tick(); tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_pending got=%0d expected=0", sb.size()); end
    endtask

    task automatic test_toggle();
        int w0;
        w0 = wr_seen;
        start(32'h40, 16'd2);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd3, 32'h00300193);
        iValid = 1'b0;
        tick();
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL toggle_ready got=%b expected=1", oReady); end
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd4, 32'd4, 32'h00400213);
        // keep offering a field set: none may be accepted
        send_extra();
        checks++; if (wr_seen - w0 != 2) begin errors++; $display("FAIL toggle_writes got=%0d expected=2", wr_seen - w0); end
    endtask

    task automatic test_back_to_back_extra_dummy();
    endtask

    task automatic send_extra();
        iImm = 32'd9; iRd = 5'd9;
        exp_word = 32'h00900493;
        iValid = 1'b1;
        checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL extra_ready got=%b expected=0", oReady); end
        tick(); tick(); tick();
        iValid = 1'b0;
    endtask

    task automatic test_async_reset();
        int w0;
        start(32'h200, 16'd3);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h00500093);
        iValid = 1'b0;
        tick();
        w0 = wr_seen;
        #2 iRstN = 1'b0;
        #1;
        checks++; if ({oMemWe, oBusy, oReady, oDone} !== 4'b0) begin errors++; $display("FAIL arst_status got=%b expected=0000", {oMemWe, oBusy, oReady, oDone}); end
        checks++; if ({oMemAddr, oMemWData} !== 64'd0) begin errors++; $display("FAIL arst_port got=%h expected=0", {oMemAddr, oMemWData}); end
        iValid = 1'b1;
        tick(); tick();
        iRstN = 1'b1;
        tick(); tick(); tick();
        iValid = 1'b0;
        checks++; if (wr_seen != w0) begin errors++; $display("FAIL arst_writes got=%0d expected=%0d", wr_seen, w0); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b expected=0", oBusy); end
        // a fresh load works; illegal format writes a nop and flags oError
        start(32'h300, 16'd1);
        send(3'd7, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'h00000013);
        iValid = 1'b0;
        checks++; if (oError !== 1'b1) begin errors++; $display("FAIL illegal_error got=%b expected=1", oError); end
        tick(); tick(); tick();
        checks++; if (oError !== 1'b1) begin errors++; $display("FAIL illegal_sticky got=%b expected=1", oError); end
    endtask

    task automatic test_checks();
        start(32'h400, 16'd1);
        checks++; if (oError !== 1'b0) begin errors++; $display("FAIL chk_clear got=%b expected=0", oError); end
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd7, 32'h00208363);
        iValid = 1'b0;
        checks++; if (oError !== CHK_ERR) begin errors++; $display("FAIL chk_beq_error got=%b expected=%b", oError, CHK_ERR); end
        tick(); tick(); tick();
    endtask

    initial begin
        iRstN = 1'b0; iStart = 1'b0; iBaseAddr = '0; iCount = '0; iValid = 1'b0;
        iFormat = '0; iOpCode = '0; iFunct3 = '0; iFunct7 = '0;
        iRs1 = '0; iRs2 = '0; iRd = '0; iImm = '0;
        exp_word = '0; m_addr = '0; hs = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        test_reset();
        iRstN = 1'b1;
        tick();
        test_program();
        test_u_j();
        test_count_zero();
        test_wrap();
        test_toggle();
        test_async_reset();
        test_checks();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL final_pending got=%0d expected=0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
